stage_fetch_q: RTL and testbench

Parametrised successor to the single-entry fetch stage. It sits between instruction memory and the decode stage. A DEPTH-entry prefetch queue of {pc, insn} pairs lets fetch run ahead while decode stalls. A decode redirect (de_setpc) flushes the queue and restarts fetch at de_newpc in the same cycle.

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_queue.sv | 64 ++++++
 rtl/stage_fetch_q.sv | 95 +++++++++
 tb/tb_stage_fetch_q.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch types: default XLEN / reset PC, the {pc, insn} queue entry and a DEPTH sanity check.
package fetch_pkg;

    localparam int unsigned     XLEN_DEF     = 32;
    localparam logic [31:0]     RESET_PC_DEF = 32'h8000_0000;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [XLEN_DEF-1:0] insn;
    } fetch_entry_t;

    function automatic bit depth_ok(input int unsigned d);
        return (d >= 2) && ((d & (d - 1)) == 0);
    endfunction

endpackage

// Elaboration-time guard: pointer wrap relies on DEPTH being a power of two >= 2.
`define FETCH_CHECK_DEPTH(D) \
    if (!fetch_pkg::depth_ok(D)) begin : g_bad_depth \
        $error("DEPTH must be a power of two and at least 2"); \
    end

// File: rtl/fetch_queue.sv
// Prefetch FIFO of fetch entries; flush clears it, flush_push flushes and writes entry 0 in one cycle.
// Head is a combinational read of registered storage; no internal overflow protection.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter type         entry_t = fetch_entry_t,
    parameter int unsigned DEPTH   = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic                     flush_push,
    input  entry_t                   wr_dat,
    output entry_t                   head_dat,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    entry_t          mem_q [DEPTH];
    logic [AW-1:0]   rd_q, rd_d, wr_q, wr_d, waddr;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            we;

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        we    = 1'b0;
        waddr = wr_q;
        if (flush) begin
            rd_d  = '0;
            wr_d  = AW'(flush_push);
            cnt_d = CW'(flush_push);
            we    = flush_push;
            waddr = '0;
        end else begin
            rd_d  = rd_q + AW'(pop);
            wr_d  = wr_q + AW'(push);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
            we    = push;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
            if (we) mem_q[waddr] <= wr_dat;
        end
    end

    assign head_dat = mem_q[rd_q];
    assign count    = cnt_q;

endmodule

// File: rtl/stage_fetch_q.sv
// Fetch stage with DEPTH-entry prefetch queue; 1-cycle ack-to-decode latency, stalls only when full and not popping.
// Optional STAGE_FETCH_Q_PERF_EN adds fetch and queue-full-stall counters.
module stage_fetch_q
    import fetch_pkg::*;
#(
    parameter int unsigned     XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF),
    parameter int unsigned     DEPTH    = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   de_stall,
    input  logic                   de_setpc,
    input  logic [XLEN-1:0]        de_newpc,
    output logic                   fe_req,
    output logic [XLEN-1:0]        fe_addr,
    input  logic                   fe_ack,
    input  logic [XLEN-1:0]        fe_data,
    output logic                   de_valid,
    output logic [XLEN-1:0]        de_insn,
    output logic [XLEN-1:0]        de_pc,
    output logic [$clog2(DEPTH):0] fe_level
`ifdef STAGE_FETCH_Q_PERF_EN
    ,
    output logic [31:0]            perf_fetch_cnt,
    output logic [31:0]            perf_full_cnt
`endif
);
    localparam int unsigned   LW       = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] insn;
    } entry_t;

    `FETCH_CHECK_DEPTH(DEPTH)

    logic [XLEN-1:0] fe_pc_q, fe_pc_d;
    logic            push, pop;
    entry_t          wr_dat, head_dat;

    assign pop      = de_valid & ~de_stall & ~de_setpc;
    assign fe_addr  = de_setpc ? de_newpc : fe_pc_q;
    assign fe_req   = de_setpc | (fe_level != FULL_LVL) | pop;
    assign push     = fe_req & fe_ack;
    assign de_valid = (fe_level != '0);
    assign de_pc    = head_dat.pc;
    assign de_insn  = head_dat.insn;
    assign wr_dat   = '{pc: fe_addr, insn: fe_data};

    // fe_addr already carries a pending redirect, so an un-acked target is held here
    assign fe_pc_d  = push ? fe_addr + XLEN'(4) : fe_addr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) fe_pc_q <= RESET_PC;
        else          fe_pc_q <= fe_pc_d;
    end

    fetch_queue #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_queue (
        .clk        (clk),
        .reset_n    (reset_n),
        .push       (push),
        .pop        (pop),
        .flush      (de_setpc),
        .flush_push (de_setpc & push),
        .wr_dat     (wr_dat),
        .head_dat   (head_dat),
        .count      (fe_level)
    );

`ifdef STAGE_FETCH_Q_PERF_EN
    logic [31:0] perf_fetch_q, perf_fetch_d, perf_full_q, perf_full_d;

    assign perf_fetch_d = perf_fetch_q + 32'(push);
    assign perf_full_d  = perf_full_q + 32'((fe_level == FULL_LVL) & ~pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetch_q <= '0;
            perf_full_q  <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_full_q  <= perf_full_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_full_cnt  = perf_full_q;
`endif

endmodule

// File: tb/tb_stage_fetch_q.sv
// Bench for stage_fetch_q: vector table with hand-derived occupancy/request plus a queue scoreboard.
module tb_stage_fetch_q;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h8000_0000;
    localparam logic [31:0] KEY   = 32'h5A5A_0F0F;

    logic        clk, reset_n, de_stall, de_setpc, fe_ack, fe_req, de_valid;
    logic [31:0] de_newpc, fe_addr, fe_data, de_insn, de_pc;
    logic [2:0]  fe_level;

    logic        w_rst_n, w_stall, w_setpc, w_ack, w_req, w_valid;
    logic [31:0] w_newpc, w_addr, w_data, w_insn, w_pc;
    logic [2:0]  w_level;

`ifdef STAGE_FETCH_Q_PERF_EN
    logic [31:0] perf_fetch_cnt, perf_full_cnt, w_perf_fetch, w_perf_full;
`endif

    assign fe_data = fe_addr ^ KEY;
    assign w_data  = w_addr ^ KEY;

    stage_fetch_q #(.RESET_PC(RPC), .DEPTH(DEPTH), .XLEN(32)) dut (
        .clk(clk), .reset_n(reset_n), .de_stall(de_stall), .de_setpc(de_setpc),
        .de_newpc(de_newpc), .fe_req(fe_req), .fe_addr(fe_addr), .fe_ack(fe_ack),
        .fe_data(fe_data), .de_valid(de_valid), .de_insn(de_insn), .de_pc(de_pc),
        .fe_level(fe_level)
`ifdef STAGE_FETCH_Q_PERF_EN
        , .perf_fetch_cnt(perf_fetch_cnt), .perf_full_cnt(perf_full_cnt)
`endif
    );

    stage_fetch_q #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH), .XLEN(32)) u_wrap (
        .clk(clk), .reset_n(w_rst_n), .de_stall(w_stall), .de_setpc(w_setpc),
        .de_newpc(w_newpc), .fe_req(w_req), .fe_addr(w_addr), .fe_ack(w_ack),
        .fe_data(w_data), .de_valid(w_valid), .de_insn(w_insn), .de_pc(w_pc),
        .fe_level(w_level)
`ifdef STAGE_FETCH_Q_PERF_EN
        , .perf_fetch_cnt(w_perf_fetch), .perf_full_cnt(w_perf_full)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    endfunction

    // Scoreboard: entries queued when an acked fetch is driven, retired when decode consumes them.
    typedef struct packed { logic [31:0] pc; logic [31:0] insn; } ent_t;
    ent_t        m_q[$];
    logic [31:0] m_pc;
    int unsigned m_fetch, m_full;

    task automatic step(input logic st, input logic sp, input logic [31:0] np, input logic ak);
        logic [31:0] exp_addr;
        logic        pop, req;
        @(negedge clk);
        de_stall = st; de_setpc = sp; de_newpc = np; fe_ack = ak;
        #1;
        exp_addr = sp ? np : m_pc;
        pop      = (m_q.size() != 0) && !st && !sp;
        req      = sp || (m_q.size() != DEPTH) || pop;
        check("fe_addr", fe_addr, exp_addr);
        check("fe_req", 32'(fe_req), 32'(req));
        check("de_valid", 32'(de_valid), 32'(m_q.size() != 0));
        check("fe_level", 32'(fe_level), 32'(m_q.size()));
        if (m_q.size() != 0) begin
            check("de_pc", de_pc, m_q[0].pc);
            check("de_insn", de_insn, m_q[0].insn);
        end
`ifdef STAGE_FETCH_Q_PERF_EN
        check("perf_fetch", perf_fetch_cnt, m_fetch);
        check("perf_full", perf_full_cnt, m_full);
`endif
        if (m_q.size() == DEPTH && !pop) m_full++;
        if (sp) m_q.delete();
        else if (pop) void'(m_q.pop_front());
        if (req && ak) begin
            m_q.push_back('{pc: exp_addr, insn: exp_addr ^ KEY});
            m_fetch++;
        end
        m_pc = (req && ak) ? exp_addr + 32'd4 : exp_addr;
    endtask

    typedef struct {
        logic        st, sp;
        logic [31:0] np;
        logic        ak;
        logic [2:0]  lvl;
        logic        req;
    } vec_t;

    function automatic vec_t mkv(input logic st, input logic sp, input logic [31:0] np,
                                 input logic ak, input logic [2:0] lvl, input logic req);
        vec_t v;
        v.st = st; v.sp = sp; v.np = np; v.ak = ak; v.lvl = lvl; v.req = req;
        return v;
    endfunction

    vec_t        vt[23];
    logic [31:0] wexp[4];

    initial begin
        // streaming, no stall
        for (int i = 0; i < 4; i++) vt[i] = mkv(1'b0, 1'b0, 32'h0, 1'b1, (i == 0) ? 3'd0 : 3'd1, 1'b1);
        // stall fills the queue; no request once full
        vt[4]  = mkv(1'b1, 1'b0, 32'h0, 1'b1, 3'd1, 1'b1);
        vt[5]  = mkv(1'b1, 1'b0, 32'h0, 1'b1, 3'd2, 1'b1);
        vt[6]  = mkv(1'b1, 1'b0, 32'h0, 1'b1, 3'd3, 1'b1);
        for (int i = 7; i < 10; i++) vt[i] = mkv(1'b1, 1'b0, 32'h0, 1'b1, 3'd4, 1'b0);
        // full queue, push and pop together
        for (int i = 10; i < 14; i++) vt[i] = mkv(1'b0, 1'b0, 32'h0, 1'b1, 3'd4, 1'b1);
        // redirect on a full queue, acked
        vt[14] = mkv(1'b0, 1'b1, 32'h8000_0100, 1'b1, 3'd4, 1'b1);
        vt[15] = mkv(1'b0, 1'b0, 32'h0, 1'b0, 3'd1, 1'b1);
        // redirect with memory withholding ack
        vt[16] = mkv(1'b0, 1'b1, 32'h8000_0200, 1'b0, 3'd0, 1'b1);
        for (int i = 17; i < 20; i++) vt[i] = mkv(1'b0, 1'b0, 32'h0, 1'b0, 3'd0, 1'b1);
        vt[20] = mkv(1'b0, 1'b0, 32'h0, 1'b1, 3'd0, 1'b1);
        vt[21] = mkv(1'b1, 1'b0, 32'h0, 1'b1, 3'd1, 1'b1);
        vt[22] = mkv(1'b1, 1'b0, 32'h0, 1'b1, 3'd2, 1'b1);
        wexp[0] = 32'hFFFF_FFF8; wexp[1] = 32'hFFFF_FFFC; wexp[2] = 32'h0000_0000; wexp[3] = 32'h0000_0004;

        reset_n = 1'b1; w_rst_n = 1'b0;
        de_stall = 1'b0; de_setpc = 1'b0; de_newpc = '0; fe_ack = 1'b0;
        w_stall = 1'b0; w_setpc = 1'b0; w_newpc = '0; w_ack = 1'b1;
        m_pc = RPC; m_fetch = 0; m_full = 0;
        #1 reset_n = 1'b0;
        #11;
        check("rst_valid", 32'(de_valid), 32'd0);
        check("rst_level", 32'(fe_level), 32'd0);
        check("rst_req", 32'(fe_req), 32'd1);
        check("rst_addr", fe_addr, RPC);
        check("rst_pc", de_pc, 32'd0);
        check("rst_insn", de_insn, 32'd0);
        @(posedge clk); #2 reset_n = 1'b1;

        for (int i = 0; i < 23; i++) begin
            step(vt[i].st, vt[i].sp, vt[i].np, vt[i].ak);
            check($sformatf("tbl_level[%0d]", i), 32'(fe_level), 32'(vt[i].lvl));
            check($sformatf("tbl_req[%0d]", i), 32'(fe_req), 32'(vt[i].req));
        end

        // asynchronous reset with three entries queued
        @(posedge clk); #2;
        check("pre_rst_level", 32'(fe_level), 32'd3);
        reset_n = 1'b0;
        #1;
        check("arst_valid", 32'(de_valid), 32'd0);
        check("arst_level", 32'(fe_level), 32'd0);
        check("arst_req", 32'(fe_req), 32'd1);
        check("arst_addr", fe_addr, RPC);
        check("arst_pc", de_pc, 32'd0);
`ifdef STAGE_FETCH_Q_PERF_EN
        check("arst_perf_fetch", perf_fetch_cnt, 32'd0);
        check("arst_perf_full", perf_full_cnt, 32'd0);
`endif
        m_q.delete(); m_pc = RPC; m_fetch = 0; m_full = 0;
        @(posedge clk); #2 reset_n = 1'b1;
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("restart_pc", de_pc, RPC);

        // PC wrap on the second instance
        @(posedge clk); #2 w_rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            check($sformatf("wrap_addr[%0d]", k), w_addr, wexp[k]);
            if (k > 0) check($sformatf("wrap_pc[%0d]", k), w_pc, wexp[k-1]);
        end
        check("wrap_level", 32'(w_level), 32'd1);
        check("wrap_valid", 32'(w_valid), 32'd1);
        check("wrap_req", 32'(w_req), 32'd1);
        check("wrap_insn", w_insn, wexp[2] ^ KEY);
`ifdef STAGE_FETCH_Q_PERF_EN
        check("wrap_perf_fetch", w_perf_fetch, 32'd3);
        check("wrap_perf_full", w_perf_full, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
